// File: rtl/player_payout_pkg.sv
// Shared constants for the player payout (win credit) path: FSM state codes,
// default score width and the legal bet values.
package payout_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COUNT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam int SCORE_W_DEF = 17;
  localparam logic [SCORE_W_DEF-1:0] SCORE_MAX = {SCORE_W_DEF{1'b1}};

  localparam logic [2:0] BET_SINGLE = 3'd1;
  localparam logic [2:0] BET_MAX    = 3'd5;

endpackage

// File: rtl/player_payout_tick_gen.sv
// Coin-rate divider: counts TICK_DIV cycles while enabled and flags the last
// cycle of each period so the next edge credits one coin.
module payout_tick_gen #(
  parameter int TICK_DIV = 500000
) (
  input  logic i_clk,
  input  logic i_resetn,
  input  logic i_clr,
  input  logic i_en,
  output logic o_term
);

  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] L_LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0] r_tick;

  assign o_term = i_en && !i_clr && (r_tick == L_LAST);

  // Period counter; clear wins over enable and wraps on the terminal count.
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_tick <= '0;
    end else if (i_clr) begin
      r_tick <= '0;
    end else if (i_en) begin
      r_tick <= o_term ? '0 : r_tick + TW'(1);
    end else begin
      r_tick <= r_tick;
    end
  end

endmodule

// File: rtl/player_payout.sv
// Adds bet*mult winnings to the player score one coin per tick period.
// Optional PAYOUT_SKIP_EN lets i_skip dump the remaining payout in one edge.
module player_payout
  import payout_pkg::*;
#(
  parameter int SCORE_W  = SCORE_W_DEF,
  parameter int BET_W    = 3,
  parameter int MULT_W   = 4,
  parameter int TICK_DIV = 500000
) (
  input  logic                    i_clock,
  input  logic                    i_resetn,
  input  logic                    i_start,
  input  logic [BET_W-1:0]        i_bet,
  input  logic [MULT_W-1:0]       i_mult,
  input  logic [SCORE_W-1:0]      i_score_in,
  input  logic                    i_skip,
  output logic                    o_ready,
  output logic                    o_busy,
  output logic [SCORE_W-1:0]      o_score_out,
  output logic [BET_W+MULT_W-1:0] o_remaining,
  output logic                    o_credit_pulse,
  output logic                    o_done,
  output logic                    o_saturated
);

  localparam int RW = BET_W + MULT_W;
  localparam logic [SCORE_W-1:0] L_MAX = {SCORE_W{1'b1}};

  logic [1:0]         r_state;
  logic               r_ready, r_busy, r_pulse, r_done, r_sat;
  logic [SCORE_W-1:0] r_score;
  logic [RW-1:0]      r_rem;
  logic [RW-1:0]      w_prod;
  logic [SCORE_W:0]   w_sum;
  logic               w_term, w_skip, w_in_count;

  assign w_prod     = RW'(i_bet) * RW'(i_mult);
  // Carry bit of w_sum flags a skip that would overflow the score.
  assign w_sum      = {1'b0, r_score} + (SCORE_W + 1)'(r_rem);
  assign w_in_count = (r_state == S_COUNT);

`ifdef PAYOUT_SKIP_EN
  assign w_skip = i_skip;
`else
  logic w_unused_skip;
  assign w_unused_skip = i_skip;
  assign w_skip        = 1'b0;
`endif

  payout_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .i_clk    (i_clock),
    .i_resetn (i_resetn),
    .i_clr    (!w_in_count),
    .i_en     (w_in_count),
    .o_term   (w_term)
  );

  // Payout FSM and all registered outputs.
  always_ff @(posedge i_clock) begin
    if (!i_resetn) begin
      r_state <= S_IDLE;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_pulse <= 1'b0;
      r_done  <= 1'b0;
      r_sat   <= 1'b0;
      r_score <= '0;
      r_rem   <= '0;
    end else begin
      r_pulse <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_score <= i_score_in;
            r_rem   <= w_prod;
            r_sat   <= 1'b0;
            r_ready <= 1'b0;
            if (w_prod == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_COUNT;
              r_busy  <= 1'b1;
            end
          end
        end
        S_COUNT: begin
          if (w_skip) begin
            r_rem   <= '0;
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            if (w_sum[SCORE_W]) begin
              r_score <= L_MAX;
              r_sat   <= 1'b1;
            end else begin
              r_score <= w_sum[SCORE_W-1:0];
            end
          end else if (w_term) begin
            r_rem   <= r_rem - RW'(1);
            r_pulse <= 1'b1;
            if (r_score == L_MAX) begin
              r_sat <= 1'b1;
            end else begin
              r_score <= r_score + SCORE_W'(1);
            end
            if (r_rem == RW'(1)) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready        = r_ready;
  assign o_busy         = r_busy;
  assign o_score_out    = r_score;
  assign o_remaining    = r_rem;
  assign o_credit_pulse = r_pulse;
  assign o_done         = r_done;
  assign o_saturated    = r_sat;

endmodule
